// File: rtl/multdiv_seq_unit_if.sv
// Start/operand/result bundle between the decode stage and the iterative mult/div unit.
// The decode stage is the master; the execution unit is the slave.
interface multdiv_seq_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             data_busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, data_busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, data_busy
    );
endinterface

// File: rtl/multdiv_seq_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Operands latch on a ctrl pulse; the result is registered with a one-cycle ready strobe.
module multdiv_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic               clock,
    input logic               reset,
    multdiv_seq_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e r_state, w_state_next;

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_m;
    logic               r_neg;
    logic               r_op_div;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;

    logic               w_start;
    logic               w_last;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_div_trial;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_div_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_mul_exc;
    logic [WIDTH-1:0]   w_quo;
    logic               w_div0;
    logic               w_div_exc;
    logic               w_busy;
    logic               w_rdy;

    assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_last  = (r_cnt == CW'(WIDTH));
    assign w_mag_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign w_mag_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient bits}
    assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_trial - {1'b0, r_m};
    assign w_div_ge    = (w_div_trial >= {1'b0, r_m});
    assign w_div_rem   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_trial[WIDTH-1:0];
    assign w_div_step  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

    assign w_prod    = r_neg ? -r_acc : r_acc;
    assign w_prod_hi = w_prod[2*WIDTH-1:WIDTH-1];
    assign w_mul_exc = ~((&w_prod_hi) | ~(|w_prod_hi));
    assign w_quo     = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_div0    = (r_m == '0);
    // A positive quotient with the top bit set is only reachable as MIN / -1
    assign w_div_exc = w_div0 | (~r_neg & r_acc[WIDTH-1]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = StRun;
        end else begin
            unique case (r_state)
                StRun:   if (w_last) w_state_next = StDone;
                StDone:  w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        w_busy = (r_state == StRun);
        w_rdy  = (r_state == StDone);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_m      <= '0;
            r_neg    <= 1'b0;
            r_op_div <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_start) begin
            r_cnt    <= '0;
            r_op_div <= ~bus.ctrl_MULT;
            r_neg    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            r_m      <= bus.ctrl_MULT ? w_mag_a : w_mag_b;
            r_acc    <= {{WIDTH{1'b0}}, (bus.ctrl_MULT ? w_mag_b : w_mag_a)};
        end else if (r_state == StRun) begin
            if (!w_last) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= r_op_div ? w_div_step : w_mul_step;
            end else if (r_op_div) begin
                r_result <= w_div0 ? '0 : w_quo;
                r_exc    <= w_div_exc;
            end else begin
                r_result <= w_prod[WIDTH-1:0];
                r_exc    <= w_mul_exc;
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = w_rdy;
    assign bus.data_busy      = w_busy;
endmodule

// File: tb/tb_multdiv_seq_unit.sv
// Directed self-checking bench for multdiv_seq_unit: latency, signs, overflow,
// divide-by-zero, reset mid-operation, abort/priority and back-to-back starts.
module tb_multdiv_seq_unit;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [31:0] exp_last;

    multdiv_seq_unit_if #(.WIDTH(32)) bus ();

    multdiv_seq_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pulse a start on the next edge (E0), then scramble operands to show they are ignored.
    task automatic drive_start(input logic m, input logic d, input logic [31:0] a,
                               input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input bit chained);
        int n;
        int bad_busy;
        int bad_hold;
        bit seen;
        n = 0;
        bad_busy = 0;
        bad_hold = 0;
        seen = 1'b0;
        drive_start(m, d, a, b);
        check({tag, "_rdy_at_start"}, 32'(bus.data_resultRDY), 32'd0);
        while (!seen && n < 40) begin
            if (bus.data_busy !== 1'b1 || bus.data_resultRDY !== 1'b0) bad_busy++;
            if (bus.data_result !== exp_last) bad_hold++;
            @(posedge clock);
            #1;
            n++;
            if (bus.data_resultRDY === 1'b1) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(n), 32'd33);
        check({tag, "_result"}, bus.data_result, er);
        check({tag, "_exception"}, 32'(bus.data_exception), 32'(ee));
        check({tag, "_busy_at_rdy"}, 32'(bus.data_busy), 32'd0);
        check({tag, "_busy_during_run"}, 32'(bad_busy), 32'd0);
        check({tag, "_hold_during_run"}, 32'(bad_hold), 32'd0);
        exp_last = er;
        if (!chained) begin
            @(posedge clock);
            #1;
            check({tag, "_rdy_one_cycle"}, 32'(bus.data_resultRDY), 32'd0);
            check({tag, "_result_holds"}, bus.data_result, er);
        end
    endtask

    initial begin
        int strobes;
        n_cmp = 0;
        n_err = 0;
        exp_last = 32'd0;
        reset = 1'b1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(negedge clock);
        check("reset_result", bus.data_result, 32'd0);
        check("reset_exception", 32'(bus.data_exception), 32'd0);
        check("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("reset_busy", 32'(bus.data_busy), 32'd0);
        reset = 1'b0;

        run_op("mul_neg3x5", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 1'b0);

        // Reset in the middle of a multiply: outputs clear at once, no strobe follows
        drive_start(1'b1, 1'b0, 32'd7, 32'd6);
        repeat (9) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("midrst_result", bus.data_result, 32'd0);
        check("midrst_exception", 32'(bus.data_exception), 32'd0);
        check("midrst_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("midrst_busy", 32'(bus.data_busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_last = 32'd0;
        strobes = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY === 1'b1) strobes++;
        end
        check("midrst_no_strobe", 32'(strobes), 32'd0);
        run_op("mul_7x6", 1'b1, 1'b0, 32'd7, 32'd6, 32'h0000_002A, 1'b0, 1'b0);

        run_op("mul_ovf_2p32", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1'b0);
        run_op("mul_ovf_max2", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 1'b0);

        run_op("div_neg7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("div_by_zero", 1'b0, 1'b1, 32'd100, 32'd0, 32'h0, 1'b1, 1'b0);
        run_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1,
               1'b0);

        // Abort: divide started, multiply pulse 12 edges later replaces it
        drive_start(1'b0, 1'b1, 32'd9, 32'd3);
        strobes = 0;
        repeat (11) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY === 1'b1) strobes++;
        end
        check("abort_no_early_strobe", 32'(strobes), 32'd0);
        run_op("abort_mul_4x4", 1'b1, 1'b0, 32'd4, 32'd4, 32'h0000_0010, 1'b0, 1'b0);

        run_op("prio_mul_8x2", 1'b1, 1'b1, 32'd8, 32'd2, 32'h0000_0010, 1'b0, 1'b0);

        // Back-to-back: the second pulse lands on the DONE cycle
        run_op("b2b_first", 1'b1, 1'b0, 32'd3, 32'd3, 32'h0000_0009, 1'b0, 1'b1);
        run_op("b2b_second", 1'b0, 1'b1, 32'd50, 32'hFFFF_FFFB, 32'hFFFF_FFF6, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
